vga_timing_gen: RTL

VGA timing generator and pixel output stage for the 640x480 @ 60 Hz display path. Generates the `DrawX`/`DrawY` scan coordinates that drive every sprite renderer, such as the base and tank sprites. Takes back the renderers' 4-bit RGB, which arrives a fixed number of `vga_clk` cycles after the coordinates. Delays sync and blanking by the same amount, then registers everything to the pins, so colour and sync stay aligned.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing_gen_sig_delay.sv | 30 +++
 rtl/vga_timing_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, derived scan positions and pixel types for the VGA path.
package vga_pkg;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START = H_VISIBLE_DEF + H_FP_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF;
    localparam int VS_START = V_VISIBLE_DEF + V_FP_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF;

    localparam int CNT_W = 10;

    typedef logic [3:0]       color_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// Fixed-depth shift register with an asynchronous reset value; depth 0 is a wire.
module sig_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 scan counters plus a sync/blank delay line matched to renderer latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 1
) (
    input  logic   vga_clk,
    input  logic   reset,
    output cnt_t   DrawX,
    output cnt_t   DrawY,
    output logic   active,
    output logic   frame_start,
    input  color_t red,
    input  color_t green,
    input  color_t blue,
    output color_t vga_r,
    output color_t vga_g,
    output color_t vga_b,
    output logic   hsync,
    output logic   vsync,
    output logic   blank_n
);
    localparam cnt_t L_H_LAST   = cnt_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t L_V_LAST   = cnt_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t L_H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t L_V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t L_HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t L_HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t L_VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t L_VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

    cnt_t r_hc;
    cnt_t r_vc;

    logic w_hs_raw;
    logic w_vs_raw;
    logic w_hs_d;
    logic w_vs_d;
    logic w_act_d;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == L_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == L_V_LAST) ? '0 : r_vc + cnt_t'(1);
        end else begin
            r_hc <= r_hc + cnt_t'(1);
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign active      = (r_hc < L_H_VIS) && (r_vc < L_V_VIS);
    assign frame_start = (r_hc == '0) && (r_vc == '0);
    assign w_hs_raw    = !((r_hc >= L_HS_START) && (r_hc < L_HS_END));
    assign w_vs_raw    = !((r_vc >= L_VS_START) && (r_vc < L_VS_END));

    // Syncs idle high and active idles low so a flushed pipe shows blanking, not a pulse.
    sig_delay #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sig_delay (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   ({w_hs_raw, w_vs_raw, active}),
        .o_q   ({w_hs_d, w_vs_d, w_act_d})
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
        end else begin
            vga_r   <= w_act_d ? red   : '0;
            vga_g   <= w_act_d ? green : '0;
            vga_b   <= w_act_d ? blue  : '0;
            hsync   <= w_hs_d;
            vsync   <= w_vs_d;
            blank_n <= w_act_d;
        end
    end
endmodule
